spi_bus_arbiter: RTL and testbench

- Shares the single SPI pin set (flash_clk, flash_io0 out/oe, flash_csb, CODEC_CS) between two masters.
  - Requester A: the codec configurator SPI master.
  - Requester B: the SoC flash controller.
- Replaces the static select on codec_conf_done with a req/gnt handshake.
- Inserts a guard interval with both chip selects high between owners, so neither device sees a truncated transaction.
- Sits at top level between the two masters and the pins; all inputs are synchronous to clk.

---
 rtl/spi_bus_arbiter_if.sv | 37 +++
 rtl/spi_bus_arbiter.sv | 133 +++++++++++++
 tb/tb_spi_bus_arbiter.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/spi_bus_arbiter_if.sv
// rtl/spi_bus_arbiter_if.sv - requester handshakes, requester SPI signals and shared pin set
interface spi_bus_arbiter_if;
    logic       a_req;
    logic       a_gnt;
    logic       a_sck;
    logic       a_mosi;
    logic       a_cs_n;
    logic       b_req;
    logic       b_gnt;
    logic       b_sck;
    logic       b_mosi;
    logic       b_io0_oe;
    logic       b_cs_n;
    logic       bus_sck;
    logic       bus_mosi;
    logic       bus_io0_oe;
    logic       flash_cs_n;
    logic       codec_cs_n;
    logic [1:0] owner;
    logic       hold_timeout;

    modport slave (
        input  a_req, a_sck, a_mosi, a_cs_n,
        input  b_req, b_sck, b_mosi, b_io0_oe, b_cs_n,
        output a_gnt, b_gnt,
        output bus_sck, bus_mosi, bus_io0_oe, flash_cs_n, codec_cs_n,
        output owner, hold_timeout
    );

    modport master (
        output a_req, a_sck, a_mosi, a_cs_n,
        output b_req, b_sck, b_mosi, b_io0_oe, b_cs_n,
        input  a_gnt, b_gnt,
        input  bus_sck, bus_mosi, bus_io0_oe, flash_cs_n, codec_cs_n,
        input  owner, hold_timeout
    );
endinterface

// File: rtl/spi_bus_arbiter.sv
// rtl/spi_bus_arbiter.sv - round-robin req/gnt arbiter sharing the SPI pins between codec configurator and flash controller
module spi_bus_arbiter #(
    parameter int unsigned GUARD_CYCLES = 4,
    parameter int unsigned HOLD_LIMIT   = 65535
) (
    input  logic               clk,
    input  logic               resetn,
    spi_bus_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2,
        GUARD = 2'd3
    } state_t;

    localparam logic [7:0]  GUARD_INIT = 8'(GUARD_CYCLES - 1);
    localparam logic [15:0] HOLD_MAX   = 16'(HOLD_LIMIT);

    state_t      state_q, state_d;
    logic [7:0]  guard_q, guard_d;
    logic [15:0] hold_q, hold_d;
    logic        last_b_q, last_b_d;
    logic        a_gnt_q, a_gnt_d;
    logic        b_gnt_q, b_gnt_d;
    logic        hto_q, hto_d;

    logic        pick_a;
    logic        pick_b;
    logic [15:0] hold_inc;

    // On a tie the requester that did not own the bus last wins.
    assign pick_a   = bus.a_req && (!bus.b_req || last_b_q);
    assign pick_b   = bus.b_req && (!bus.a_req || !last_b_q);
    assign hold_inc = (hold_q == HOLD_MAX) ? hold_q : hold_q + 16'd1;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= IDLE;
            guard_q  <= 8'd0;
            hold_q   <= 16'd0;
            last_b_q <= 1'b1;
            a_gnt_q  <= 1'b0;
            b_gnt_q  <= 1'b0;
            hto_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            guard_q  <= guard_d;
            hold_q   <= hold_d;
            last_b_q <= last_b_d;
            a_gnt_q  <= a_gnt_d;
            b_gnt_q  <= b_gnt_d;
            hto_q    <= hto_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        guard_d  = guard_q;
        hold_d   = hold_q;
        last_b_d = last_b_q;
        a_gnt_d  = a_gnt_q;
        b_gnt_d  = b_gnt_q;
        hto_d    = hto_q;
        case (state_q)
            IDLE, GUARD: begin
                if (state_q == IDLE || guard_q == 8'd0) begin
                    if (pick_a) begin
                        state_d = OWN_A;
                        a_gnt_d = 1'b1;
                        hold_d  = 16'd0;
                        hto_d   = 1'b0;
                    end else if (pick_b) begin
                        state_d = OWN_B;
                        b_gnt_d = 1'b1;
                        hold_d  = 16'd0;
                        hto_d   = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    guard_d = guard_q - 8'd1;
                end
            end
            OWN_A, OWN_B: begin
                if ((state_q == OWN_A) ? !bus.a_req : !bus.b_req) begin
                    state_d  = GUARD;
                    a_gnt_d  = 1'b0;
                    b_gnt_d  = 1'b0;
                    last_b_d = (state_q == OWN_B);
                    guard_d  = GUARD_INIT;
                    hold_d   = 16'd0;
                    hto_d    = 1'b0;
                end else begin
                    hold_d = hold_inc;
                    hto_d  = (hold_inc == HOLD_MAX);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pin mux keyed on registered state only; anything but OWN_x parks the bus.
    always_comb begin
        bus.bus_sck    = 1'b0;
        bus.bus_mosi   = 1'b0;
        bus.bus_io0_oe = 1'b0;
        bus.flash_cs_n = 1'b1;
        bus.codec_cs_n = 1'b1;
        case (state_q)
            OWN_A: begin
                bus.bus_sck    = bus.a_sck;
                bus.bus_mosi   = bus.a_mosi;
                bus.bus_io0_oe = 1'b1;
                bus.codec_cs_n = bus.a_cs_n;
            end
            OWN_B: begin
                bus.bus_sck    = bus.b_sck;
                bus.bus_mosi   = bus.b_mosi;
                bus.bus_io0_oe = bus.b_io0_oe;
                bus.flash_cs_n = bus.b_cs_n;
            end
            default: ;
        endcase
    end

    assign bus.a_gnt        = a_gnt_q;
    assign bus.b_gnt        = b_gnt_q;
    assign bus.owner        = {b_gnt_q, a_gnt_q};
    assign bus.hold_timeout = hto_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// tb/tb_spi_bus_arbiter.sv - directed vector table, corner sequences and random invariants for spi_bus_arbiter
module tb_spi_bus_arbiter;

    localparam int G = 4;
    localparam int H = 10;

    logic clk = 1'b0;
    logic resetn;
    int   tests = 0;
    int   failed = 0;

    spi_bus_arbiter_if ifc ();

    spi_bus_arbiter #(
        .GUARD_CYCLES (G),
        .HOLD_LIMIT   (H)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (ifc)
    );

    always #5 clk = ~clk;

    // in  = {a_req,b_req, a_sck,a_mosi,a_cs_n, b_sck,b_mosi,b_io0_oe,b_cs_n}
    // exp = {a_gnt,b_gnt, owner[1:0], hold_timeout, bus_sck,bus_mosi,bus_io0_oe, flash_cs_n,codec_cs_n}
    typedef struct {
        logic [8:0] in;
        logic [9:0] exp;
    } vec_t;

    localparam logic [9:0] IDLE_E = 10'b00_00_0_000_11;

    vec_t vecs[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [8:0] v);
        {ifc.a_req, ifc.b_req, ifc.a_sck, ifc.a_mosi, ifc.a_cs_n,
         ifc.b_sck, ifc.b_mosi, ifc.b_io0_oe, ifc.b_cs_n} = v;
    endtask

    function automatic logic [9:0] outs();
        return {ifc.a_gnt, ifc.b_gnt, ifc.owner, ifc.hold_timeout, ifc.bus_sck,
                ifc.bus_mosi, ifc.bus_io0_oe, ifc.flash_cs_n, ifc.codec_cs_n};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            if (failed <= 30)
                $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [8:0] in, input logic [9:0] exp);
        vec_t v;
        v.in  = in;
        v.exp = exp;
        vecs.push_back(v);
    endtask

    initial begin
        int waited;
        int nogap;
        logic prev_any;
        logic any;
        logic ok;

        add(9'b0_0_101_1010, IDLE_E);                 // idle pins ignore requester signals
        add(9'b1_0_110_0001, 10'b10_01_0_111_10);     // A granted from IDLE
        add(9'b1_1_000_0000, 10'b10_01_0_001_10);
        add(9'b0_1_100_1110, IDLE_E);                 // A releases -> GUARD
        add(9'b0_1_000_0000, IDLE_E);
        add(9'b0_1_000_0000, IDLE_E);
        add(9'b0_1_000_0000, IDLE_E);
        add(9'b0_1_000_1110, 10'b01_10_0_111_01);     // B, 5 cycles after release
        add(9'b0_1_000_0000, 10'b01_10_0_000_01);
        add(9'b1_0_000_0000, IDLE_E);                 // B releases, A waiting
        add(9'b1_1_000_0000, IDLE_E);
        add(9'b1_0_000_0000, IDLE_E);
        add(9'b1_1_000_0000, IDLE_E);
        add(9'b1_1_100_0000, 10'b10_01_0_101_10);     // tie after B -> A
        add(9'b0_1_000_0000, IDLE_E);
        add(9'b0_1_000_0000, IDLE_E);
        add(9'b0_1_000_0000, IDLE_E);
        add(9'b0_1_000_0000, IDLE_E);
        add(9'b0_1_000_0011, 10'b01_10_0_001_11);
        add(9'b0_0_000_0000, IDLE_E);
        add(9'b1_0_000_0000, IDLE_E);                 // A pulse inside GUARD is lost
        add(9'b0_0_000_0000, IDLE_E);
        add(9'b0_1_000_0000, IDLE_E);
        add(9'b0_1_000_0010, 10'b01_10_0_001_01);     // same requester re-granted
        add(9'b0_0_000_0000, IDLE_E);
        add(9'b0_0_000_0000, IDLE_E);
        add(9'b0_0_000_0000, IDLE_E);
        add(9'b0_0_000_0000, IDLE_E);
        add(9'b0_0_000_0000, IDLE_E);                 // guard expires -> IDLE
        add(9'b1_0_010_0000, 10'b10_01_0_011_10);
        add(9'b0_0_000_0000, IDLE_E);
        add(9'b0_0_000_0000, IDLE_E);
        add(9'b0_0_000_0000, IDLE_E);
        add(9'b0_0_000_0000, IDLE_E);
        add(9'b0_0_000_0000, IDLE_E);

        resetn = 1'b0;
        drive(9'b1_1_111_1110);
        step();
        step();
        check("reset_state", 16'(outs()), 16'(IDLE_E));
        resetn = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].in);
            step();
            check($sformatf("vec%0d", i), 16'(outs()), 16'(vecs[i].exp));
        end

        // Hold timeout: rises on the 11th owned cycle, grant kept.
        drive(9'b1_0_000_0000);
        step();
        for (int k = 1; k <= 15; k++) begin
            check($sformatf("hold_k%0d", k), {14'd0, ifc.a_gnt, ifc.hold_timeout},
                  {14'd0, 1'b1, (k >= H + 1)});
            if (k < 15) step();
        end
        ifc.a_req = 1'b0;
        step();
        check("hold_release", {14'd0, ifc.a_gnt, ifc.hold_timeout}, 16'd0);
        for (int k = 0; k < G; k++) step();

        // Reset in the middle of a B transfer.
        drive(9'b0_1_000_1100);
        step();
        check("b_mid_xfer", {14'd0, ifc.b_gnt, ifc.flash_cs_n}, 16'b10);
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        check("reset_mid_xfer", {12'd0, ifc.flash_cs_n, ifc.b_gnt, ifc.owner}, 16'b1000);
        ifc.a_req = 1'b1;
        step();
        check("tie_after_reset", {14'd0, ifc.owner}, 16'd1);
        ifc.a_req = 1'b0;
        waited = 0;
        while (!ifc.b_gnt && waited < 20) begin
            step();
            waited++;
        end
        check("b_regrant_gap", 16'(waited), 16'(G + 1));

        // Random traffic with invariant checks.
        nogap    = 255;
        prev_any = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(15) == 0) ifc.a_req = ~ifc.a_req;
            if ($urandom_range(15) == 0) ifc.b_req = ~ifc.b_req;
            {ifc.a_sck, ifc.a_mosi, ifc.a_cs_n, ifc.b_sck, ifc.b_mosi, ifc.b_io0_oe, ifc.b_cs_n} =
                7'($urandom);
            step();
            any = ifc.a_gnt | ifc.b_gnt;
            ok  = !(ifc.a_gnt && ifc.b_gnt) && (ifc.owner == {ifc.b_gnt, ifc.a_gnt}) &&
                  (ifc.a_gnt || ifc.codec_cs_n) && (ifc.b_gnt || ifc.flash_cs_n) &&
                  (any || !ifc.hold_timeout);
            check("rand_invariant", 16'(ok), 16'd1);
            if (any && !prev_any)
                check("rand_guard_gap", 16'(nogap >= G), 16'd1);
            nogap    = any ? 0 : ((nogap < 255) ? nogap + 1 : 255);
            prev_any = any;
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
